// File: rtl/keyword_match_multi.sv
// keyword_match_multi
//   Scans an AXI-Stream text frame for any of NUM_KW null-terminated keywords, including
//   matches that straddle beat boundaries, and reports the winning slot and the frame byte
//   offset of the matched keyword's last byte. The result is held until ack.
// Ports
//   clk, reset_n           clock, synchronous active-low reset
//   keywords, kw_enable    keyword slots (first char in MSByte of each slot) and per-slot enables;
//                          latched when a frame starts
//   s_axis_text_*          text stream (byte 0 = bits [7:0] is earliest), tuser = frame error
//   match_sig/no_match_sig frame outcome, held until ack
//   match_idx/match_offset winning slot and end offset (offset saturates at 0xFFFF)
//   frame_err              tuser sampled on the tlast beat
//   ack                    consumer acknowledge; only honoured while a result is held
module keyword_match_multi #(
  parameter int DATA_WIDTH       = 64,
  parameter int KW_MAX_LEN       = 16,
  parameter int NUM_KW           = 4,
  parameter bit CASE_INSENSITIVE = 1'b1,
  localparam int BYTES = DATA_WIDTH / 8,
  localparam int IDX_W = (NUM_KW > 1) ? $clog2(NUM_KW) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_KW*KW_MAX_LEN*8-1:0] keywords,
  input  logic [NUM_KW-1:0]              kw_enable,
  input  logic [DATA_WIDTH-1:0]          s_axis_text_tdata,
  input  logic [BYTES-1:0]               s_axis_text_tkeep,
  input  logic                           s_axis_text_tvalid,
  output logic                           s_axis_text_tready,
  input  logic                           s_axis_text_tlast,
  input  logic                           s_axis_text_tuser,
  output logic                           match_sig,
  output logic                           no_match_sig,
  output logic [IDX_W-1:0]               match_idx,
  output logic [15:0]                    match_offset,
  output logic                           frame_err,
  input  logic                           ack
);
  // History depth; kept at least 1 so the arrays stay legal when KW_MAX_LEN is 1.
  localparam int HS    = (KW_MAX_LEN > 1) ? KW_MAX_LEN - 1 : 1;
  localparam int WIN   = HS + BYTES;
  localparam int LEN_W = $clog2(KW_MAX_LEN + 1);
  localparam int CNT_W = $clog2(BYTES + 1);

  typedef enum logic [1:0] {IDLE, MATCHING, DRAIN, RESULT} state_t;

  state_t                   state_reg, state_next;
  logic                     tready_reg;
  logic                     match_sig_reg, no_match_sig_reg, frame_err_reg;
  logic [IDX_W-1:0]         match_idx_reg;
  logic [15:0]              match_offset_reg;
  logic [15:0]              cnt_reg;
  logic [7:0]               hist_reg   [HS];
  logic [7:0]               kw_rev_reg [NUM_KW][KW_MAX_LEN];
  logic [LEN_W-1:0]         kw_len_reg [NUM_KW];
  logic [NUM_KW-1:0]        kw_en_reg;

  logic [7:0]               kw_rev_in  [NUM_KW][KW_MAX_LEN];
  logic [LEN_W-1:0]         kw_len_in  [NUM_KW];
  logic [7:0]               win        [WIN];
  logic [7:0]               hist_next  [HS];
  logic [BYTES*NUM_KW-1:0]  hit;
  logic [CNT_W-1:0]         n_valid, win_pos;
  logic [IDX_W-1:0]         win_slot;
  logic                     any_hit, beat;
  logic [16:0]              cnt_sum, off_sum;
  logic [15:0]              cnt_next, off_next;

  function automatic logic [7:0] fold(input logic [7:0] b);
    if (CASE_INSENSITIVE && b >= 8'h41 && b <= 8'h5A) return b | 8'h20;
    return b;
  endfunction

  function automatic logic [LEN_W-1:0] kw_length(input logic [KW_MAX_LEN*8-1:0] slot);
    logic [LEN_W-1:0] len;
    logic             found;
    len   = LEN_W'(KW_MAX_LEN);
    found = 1'b0;
    for (int m = 0; m < KW_MAX_LEN; m++) begin
      if (!found && slot[(KW_MAX_LEN-1-m)*8 +: 8] == 8'h00) begin
        len   = LEN_W'(m);
        found = 1'b1;
      end
    end
    return len;
  endfunction

  assign beat = s_axis_text_tvalid && tready_reg;

  // Keywords are stored last-character-first and already folded, so that element d of a
  // slot always lines up with window byte (end_position - d) and the compare needs no
  // length-dependent muxing on the data side.
  always_comb begin
    for (int k = 0; k < NUM_KW; k++) begin
      kw_len_in[k] = kw_length(keywords[k*KW_MAX_LEN*8 +: KW_MAX_LEN*8]);
      for (int d = 0; d < KW_MAX_LEN; d++) begin
        kw_rev_in[k][d] = 8'h00;
        if (d < int'(kw_len_in[k]))
          kw_rev_in[k][d] = fold(keywords[k*KW_MAX_LEN*8 + (KW_MAX_LEN - int'(kw_len_in[k]) + d)*8 +: 8]);
      end
    end
  end

  // Window in stream order: history (oldest first) followed by this beat. Masked bytes
  // become 0x00, which no keyword character can equal.
  always_comb begin
    for (int i = 0; i < HS; i++) win[i] = hist_reg[i];
    n_valid = '0;
    for (int j = 0; j < BYTES; j++) begin
      win[HS+j] = s_axis_text_tkeep[j] ? fold(s_axis_text_tdata[j*8 +: 8]) : 8'h00;
      n_valid   = n_valid + CNT_W'(s_axis_text_tkeep[j]);
    end
    // tkeep is contiguous from bit 0, so the newest history is the window shifted by n_valid.
    for (int i = 0; i < HS; i++) hist_next[i] = win[i + int'(n_valid)];
  end

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_pos
    for (genvar gk = 0; gk < NUM_KW; gk++) begin : g_slot
      logic eq;
      always_comb begin
        eq = s_axis_text_tkeep[gi] && kw_en_reg[gk] && (kw_len_reg[gk] != '0);
        for (int d = 0; d < KW_MAX_LEN; d++) begin
          if (d < int'(kw_len_reg[gk]) && win[HS+gi-d] != kw_rev_reg[gk][d]) eq = 1'b0;
        end
      end
      assign hit[gi*NUM_KW+gk] = eq;
    end
  end

  // Earliest end position wins; within a position the lowest slot wins.
  always_comb begin
    any_hit  = 1'b0;
    win_pos  = '0;
    win_slot = '0;
    for (int j = 0; j < BYTES; j++) begin
      for (int k = 0; k < NUM_KW; k++) begin
        if (!any_hit && hit[j*NUM_KW+k]) begin
          any_hit  = 1'b1;
          win_pos  = CNT_W'(j);
          win_slot = IDX_W'(k);
        end
      end
    end
    cnt_sum  = {1'b0, cnt_reg} + 17'(n_valid);
    off_sum  = {1'b0, cnt_reg} + 17'(win_pos);
    cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    off_next = off_sum[16] ? 16'hFFFF : off_sum[15:0];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (s_axis_text_tvalid) state_next = MATCHING;
      MATCHING: if (beat) begin
                  if (s_axis_text_tlast) state_next = RESULT;
                  else if (any_hit)      state_next = DRAIN;
                end
      DRAIN:    if (beat && s_axis_text_tlast) state_next = RESULT;
      RESULT:   if (ack) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      tready_reg       <= 1'b0;
      match_sig_reg    <= 1'b0;
      no_match_sig_reg <= 1'b0;
      frame_err_reg    <= 1'b0;
      match_idx_reg    <= '0;
      match_offset_reg <= '0;
      cnt_reg          <= '0;
      kw_en_reg        <= '0;
      for (int i = 0; i < HS; i++) hist_reg[i] <= 8'h00;
      for (int k = 0; k < NUM_KW; k++) begin
        kw_len_reg[k] <= '0;
        for (int d = 0; d < KW_MAX_LEN; d++) kw_rev_reg[k][d] <= 8'h00;
      end
    end else begin
      state_reg  <= state_next;
      tready_reg <= (state_next == MATCHING) || (state_next == DRAIN);
      case (state_reg)
        IDLE: if (s_axis_text_tvalid) begin
          kw_en_reg        <= kw_enable;
          kw_len_reg       <= kw_len_in;
          kw_rev_reg       <= kw_rev_in;
          cnt_reg          <= '0;
          match_idx_reg    <= '0;
          match_offset_reg <= '0;
          for (int i = 0; i < HS; i++) hist_reg[i] <= 8'h00;
        end
        MATCHING: if (beat) begin
          hist_reg <= hist_next;
          cnt_reg  <= cnt_next;
          if (any_hit) begin
            match_idx_reg    <= win_slot;
            match_offset_reg <= off_next;
          end
          if (s_axis_text_tlast) begin
            frame_err_reg    <= s_axis_text_tuser;
            match_sig_reg    <= any_hit;
            no_match_sig_reg <= !any_hit;
          end
        end
        DRAIN: if (beat && s_axis_text_tlast) begin
          frame_err_reg <= s_axis_text_tuser;
          match_sig_reg <= 1'b1;
        end
        RESULT: if (ack) begin
          match_sig_reg    <= 1'b0;
          no_match_sig_reg <= 1'b0;
          frame_err_reg    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign s_axis_text_tready = tready_reg;
  assign match_sig          = match_sig_reg;
  assign no_match_sig       = no_match_sig_reg;
  assign match_idx          = match_idx_reg;
  assign match_offset       = match_offset_reg;
  assign frame_err          = frame_err_reg;

endmodule
